ahb_req_arbiter: RTL and testbench

//  Round-robin arbiter and single-beat AHB master that shares the ahb_dut (AHB-to-I2C slave)

---
 rtl/ahb_req_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ahb_req_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter plus single-beat AHB master sharing one AHB slave between NREQ requesters.
// Pipelined address/data phases; two-cycle ERROR/RETRY/SPLIT responses cancel and re-issue.
module ahb_req_arbiter #(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned AW        = 3,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DW-1:0]        rsp_rdata,
    output logic                 rsp_err,
    output logic [1:0]           htrans,
    output logic [AW-1:0]        haddr,
    output logic                 hwrite,
    output logic [2:0]           hsize,
    output logic [2:0]           hburst,
    output logic [DW-1:0]        hwdata,
    input  logic [DW-1:0]        hrdata,
    input  logic                 hready,
    input  logic [1:0]           hresp
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] RespOkay    = 2'b00;
    localparam logic [1:0] RespError   = 2'b01;
    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    typedef enum logic [1:0] {StRun, StCancel, StReissue} state_e;

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] id;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [RW-1:0] retry;
    } xfer_t;

    state_e          fsm_q, fsm_d;
    xfer_t           ap_q, ap_d;
    xfer_t           dp_q, dp_d;
    xfer_t           hold_q, hold_d;
    logic [1:0]      cresp_q, cresp_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic            advance;
    logic            accept;
    xfer_t           new_xfer;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int unsigned k);
        return IW'((32'(base) + k) % NREQ);
    endfunction

    assign advance = hready && (hresp == RespOkay);

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!grant_found && req_valid[rr_idx(last_grant_q, k)]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx(last_grant_q, k);
            end
        end
    end

    assign accept    = hresetn && (fsm_q == StRun) && (!ap_q.valid || advance) && grant_found;
    assign req_ready = accept ? (NREQ'(1) << grant_idx) : '0;

    always_comb begin
        new_xfer       = '0;
        new_xfer.valid = 1'b1;
        new_xfer.id    = grant_idx;
        new_xfer.write = req_write[grant_idx];
        new_xfer.addr  = req_addr[grant_idx*AW +: AW];
        new_xfer.wdata = req_wdata[grant_idx*DW +: DW];
    end

    always_comb begin
        fsm_d        = fsm_q;
        ap_d         = ap_q;
        dp_d         = dp_q;
        hold_d       = hold_q;
        cresp_d      = cresp_q;
        last_grant_d = accept ? grant_idx : last_grant_q;
        rsp_valid_d  = '0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;

        unique case (fsm_q)
            StRun: begin
                if (advance) begin
                    if (dp_q.valid) begin
                        rsp_valid_d[dp_q.id] = 1'b1;
                        rsp_rdata_d          = dp_q.write ? '0 : hrdata;
                        rsp_err_d            = 1'b0;
                    end
                    dp_d = ap_q;
                    ap_d = accept ? new_xfer : '0;
                end else begin
                    if (accept) begin
                        ap_d = new_xfer;
                    end
                    if (!hready && (hresp != RespOkay)) begin
                        fsm_d   = StCancel;
                        cresp_d = hresp;
                    end
                end
            end
            StCancel: begin
                if (hready) begin
                    fsm_d = StReissue;
                    dp_d  = '0;
                    if (dp_q.valid) begin
                        if ((cresp_q == RespError) || (dp_q.retry >= RW'(MAX_RETRY))) begin
                            rsp_valid_d[dp_q.id] = 1'b1;
                            rsp_rdata_d          = '0;
                            rsp_err_d            = 1'b1;
                        end else begin
                            // Retried transfer goes out first; the pending one waits in hold.
                            ap_d       = dp_q;
                            ap_d.retry = dp_q.retry + 1'b1;
                            hold_d     = ap_q;
                        end
                    end
                end
            end
            StReissue: begin
                if (advance) begin
                    dp_d   = ap_q;
                    ap_d   = hold_q;
                    hold_d = '0;
                    fsm_d  = StRun;
                end else if (!hready && (hresp != RespOkay)) begin
                    fsm_d   = StCancel;
                    cresp_d = hresp;
                end
            end
            default: fsm_d = StRun;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            fsm_q        <= StRun;
            ap_q         <= '0;
            dp_q         <= '0;
            hold_q       <= '0;
            cresp_q      <= RespOkay;
            last_grant_q <= '0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            ap_q         <= ap_d;
            dp_q         <= dp_d;
            hold_q       <= hold_d;
            cresp_q      <= cresp_d;
            last_grant_q <= last_grant_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    // The address phase is cancelled on the second cycle of an error-class response.
    assign htrans    = (ap_q.valid && (fsm_q != StCancel)) ? TransNonseq : TransIdle;
    assign haddr     = ap_q.addr;
    assign hwrite    = ap_q.write;
    assign hsize     = 3'b000;
    assign hburst    = 3'b000;
    assign hwdata    = (dp_q.valid && dp_q.write) ? dp_q.wdata : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed bench for ahb_req_arbiter: reset, single write, round-robin, wait states,
// ERROR with a pending transfer, RETRY exhaustion and reset during a retry.
module tb_ahb_req_arbiter;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 8;

    logic            hclk = 1'b0;
    logic            hresetn;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] req_write;
    logic [AW-1:0]   a0, a1;
    logic [DW-1:0]   d0, d1;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0] rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [1:0]      htrans;
    logic [AW-1:0]   haddr;
    logic            hwrite;
    logic [2:0]      hsize;
    logic [2:0]      hburst;
    logic [DW-1:0]   hwdata;
    logic [DW-1:0]   hrdata;
    logic            hready;
    logic [1:0]      hresp;

    int vectors     = 0;
    int miscompares = 0;

    assign req_addr  = {a1, a0};
    assign req_wdata = {d1, d0};

    always #5 hclk = ~hclk;

    ahb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_RETRY(3)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .htrans    (htrans),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hburst    (hburst),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
        .hready    (hready),
        .hresp     (hresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        hresetn   = 1'b0;
        req_valid = 2'b11;
        req_write = '0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        hrdata = '0;
        hready = 1'b1;
        hresp  = 2'b00;

        // Reset
        step();
        step();
        chk("rst_htrans", 32'(htrans), 32'h0);
        chk("rst_haddr", 32'(haddr), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        req_valid = '0;
        hresetn   = 1'b1;
        step();

        // Single write from requester 0
        req_valid = 2'b01; req_write = 2'b01; a0 = 3'd3; d0 = 8'hA5;
        #1;
        chk("wr_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        chk("wr_htrans", 32'(htrans), 32'h2);
        chk("wr_haddr", 32'(haddr), 32'h3);
        chk("wr_hwrite", 32'(hwrite), 32'h1);
        chk("wr_hsize_hburst", 32'({hsize, hburst}), 32'h0);
        step();
        chk("wr_hwdata", 32'(hwdata), 32'hA5);
        chk("wr_idle", 32'(htrans), 32'h0);
        step();
        chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("wr_rsp_err", 32'(rsp_err), 32'h0);

        // Round-robin: last grant was 0, so requester 1 wins first
        req_valid = 2'b11; req_write = 2'b11; a0 = 3'd1; a1 = 3'd2; d0 = 8'h10; d1 = 8'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_req_ready", 32'(req_ready), (i % 2 == 0) ? 32'h2 : 32'h1);
            step();
            chk("rr_htrans", 32'(htrans), 32'h2);
            chk("rr_haddr", 32'(haddr), (i % 2 == 0) ? 32'h2 : 32'h1);
        end
        chk("rr_rsp0", 32'(rsp_valid), 32'h1);
        req_valid = '0;
        step();
        chk("rr_rsp1", 32'(rsp_valid), 32'h2);
        step();
        chk("rr_rsp2", 32'(rsp_valid), 32'h1);
        step();
        chk("rr_drained_rsp", 32'(rsp_valid), 32'h0);
        chk("rr_drained_htrans", 32'(htrans), 32'h0);

        // Wait states: read addr 5 stalled 3 cycles with a write to addr 6 held behind it
        req_valid = 2'b01; req_write = 2'b00; a0 = 3'd5;
        step();
        req_valid = 2'b10; req_write = 2'b10; a1 = 3'd6; d1 = 8'h77;
        chk("ws_rd_htrans", 32'(htrans), 32'h2);
        chk("ws_rd_haddr", 32'(haddr), 32'h5);
        chk("ws_rd_hwrite", 32'(hwrite), 32'h0);
        step();
        hready = 1'b0;
        #1;
        chk("ws_req_ready", 32'(req_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_hold_htrans", 32'(htrans), 32'h2);
            chk("ws_hold_haddr", 32'(haddr), 32'h6);
            chk("ws_hold_rsp", 32'(rsp_valid), 32'h0);
        end
        req_valid = '0;
        hready = 1'b1; hrdata = 8'h3C;
        step();
        hrdata = 8'h00;
        chk("ws_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ws_rsp_rdata", 32'(rsp_rdata), 32'h3C);
        chk("ws_hwdata", 32'(hwdata), 32'h77);
        step();
        chk("ws_wr_rsp", 32'(rsp_valid), 32'h2);
        chk("ws_wr_rdata", 32'(rsp_rdata), 32'h0);

        // ERROR on the data phase while another transfer waits in the address phase
        req_valid = 2'b01; req_write = 2'b11; a0 = 3'd1; d0 = 8'h11; a1 = 3'd2; d1 = 8'h22;
        step();
        req_valid = 2'b10;
        step();
        req_valid = '0;
        hready = 1'b0; hresp = 2'b01;
        chk("er_ap_haddr", 32'(haddr), 32'h2);
        step();
        chk("er_cancel_htrans", 32'(htrans), 32'h0);
        chk("er_cancel_rsp", 32'(rsp_valid), 32'h0);
        hready = 1'b1;
        step();
        hresp = 2'b00;
        chk("er_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("er_rsp_err", 32'(rsp_err), 32'h1);
        chk("er_reissue_htrans", 32'(htrans), 32'h2);
        chk("er_reissue_haddr", 32'(haddr), 32'h2);
        step();
        chk("er_hwdata", 32'(hwdata), 32'h22);
        step();
        chk("er_ok_rsp", 32'(rsp_valid), 32'h2);
        chk("er_ok_err", 32'(rsp_err), 32'h0);

        // RETRY always: four NONSEQs of the same address, then an error response
        req_valid = 2'b01; req_write = 2'b00; a0 = 3'd4;
        step();
        req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            chk("rt_nonseq", 32'(htrans), 32'h2);
            chk("rt_haddr", 32'(haddr), 32'h4);
            hready = 1'b1; hresp = 2'b00;
            step();
            chk("rt_dp_rsp", 32'(rsp_valid), 32'h0);
            hready = 1'b0; hresp = 2'b10;
            step();
            chk("rt_cancel_htrans", 32'(htrans), 32'h0);
            hready = 1'b1;
            step();
        end
        chk("rt_exhaust_rsp", 32'(rsp_valid), 32'h1);
        chk("rt_exhaust_err", 32'(rsp_err), 32'h1);
        chk("rt_exhaust_htrans", 32'(htrans), 32'h0);
        hresp = 2'b00;
        req_valid = 2'b10; req_write = 2'b00; a1 = 3'd7;
        #1;
        chk("rt_reissue_no_accept", 32'(req_ready), 32'h0);
        step();
        #1;
        chk("rt_run_accept", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        chk("rt2_nonseq", 32'(haddr), 32'h7);
        step();
        hready = 1'b0; hresp = 2'b10;
        step();
        hready = 1'b1;
        step();
        hresp = 2'b00;
        chk("rt2_requeued", 32'(htrans), 32'h2);
        hresetn = 1'b0;
        step();
        chk("rt2_rst_htrans", 32'(htrans), 32'h0);
        chk("rt2_rst_haddr", 32'(haddr), 32'h0);
        chk("rt2_rst_rsp", 32'(rsp_valid), 32'h0);
        hresetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rt2_post_rsp", 32'(rsp_valid), 32'h0);
            chk("rt2_post_htrans", 32'(htrans), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
